// File: rtl/multi_blink_if.sv
// -----------------------------------------------------------------------------
// multi_blink_if
// Configuration-write channel for multi_blink. A write is accepted on a rising
// edge where cfg_valid and cfg_ready are both high.
//   cfg_valid        master -> slave  write request
//   cfg_ready        slave  -> master block can accept a write this cycle
//   cfg_ch           master -> slave  target channel index
//   cfg_mode         master -> slave  00 OFF, 01 ON, 10 BLINK, 11 BURST
//   cfg_half_period  master -> slave  cycles per LED half-period (0 acts as 1)
//   cfg_burst        master -> slave  number of high pulses in BURST mode
// -----------------------------------------------------------------------------
interface multi_blink_if #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CH_W-1:0]        cfg_ch;
  logic [1:0]             cfg_mode;
  logic [CNT_WIDTH-1:0]   cfg_half_period;
  logic [BURST_WIDTH-1:0] cfg_burst;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_half_period, cfg_burst,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_half_period, cfg_burst,
    output cfg_ready
  );
endinterface

// File: rtl/multi_blink.sv
// -----------------------------------------------------------------------------
// multi_blink
// NUM_CH independent LED channels. Each channel is OFF, ON, BLINK (square wave,
// each level H cycles) or BURST (N pulses of H high / H low, then OFF with a
// one-cycle burst_done pulse). Channels are reprogrammed through the cfg
// interface; a write aborts whatever the target channel was doing.
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset (all channels blink at
//               RESET_HALF_PERIOD, cfg_ready low)
//   cfg         configuration write channel (slave side)
//   led         registered LED drive, bit i = channel i
//   burst_done  registered one-cycle pulse per channel when a burst completes
// -----------------------------------------------------------------------------
module multi_blink #(
  parameter int NUM_CH            = 4,
  parameter int CNT_WIDTH         = 32,
  parameter int BURST_WIDTH       = 8,
  parameter int RESET_HALF_PERIOD = 12000000
) (
  input  logic              clk,
  input  logic              reset,
  multi_blink_if.slave      cfg,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] burst_done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_ON    = 2'b01;
  localparam logic [1:0] ST_BLINK = 2'b10;
  localparam logic [1:0] ST_BURST = 2'b11;

  localparam logic [CNT_WIDTH-1:0] RST_H = CNT_WIDTH'(RESET_HALF_PERIOD);

  logic [1:0]             state_q [NUM_CH];
  logic [1:0]             state_d [NUM_CH];
  logic [CNT_WIDTH-1:0]   cnt_q   [NUM_CH];
  logic [CNT_WIDTH-1:0]   cnt_d   [NUM_CH];
  logic [CNT_WIDTH-1:0]   h_q     [NUM_CH];
  logic [CNT_WIDTH-1:0]   h_d     [NUM_CH];
  logic [BURST_WIDTH-1:0] rem_q   [NUM_CH];
  logic [BURST_WIDTH-1:0] rem_d   [NUM_CH];
  logic [NUM_CH-1:0]      led_q, led_d;
  logic [NUM_CH-1:0]      done_q, done_d;
  logic                   ready_q;
  logic                   accept;

  // Terminal count of a level: H-1, with a stored H of 0 treated as 1.
  function automatic logic [CNT_WIDTH-1:0] last_cnt(input logic [CNT_WIDTH-1:0] h);
    return (h == '0) ? '0 : h - CNT_WIDTH'(1);
  endfunction

  assign accept        = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready = ready_q;
  assign led           = led_q;
  assign burst_done    = done_q;

  always_comb begin
    led_d  = led_q;
    done_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      h_d[i]     = h_q[i];
      rem_d[i]   = rem_q[i];

      case (state_q[i])
        ST_BLINK: begin
          if (cnt_q[i] == last_cnt(h_q[i])) begin
            cnt_d[i] = '0;
            led_d[i] = ~led_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
          end
        end
        ST_BURST: begin
          if (cnt_q[i] == last_cnt(h_q[i])) begin
            cnt_d[i] = '0;
            if (led_q[i]) begin
              led_d[i] = 1'b0;
            end else if (rem_q[i] <= BURST_WIDTH'(1)) begin
              // End of the last low phase: the burst is complete.
              state_d[i] = ST_OFF;
              rem_d[i]   = '0;
              led_d[i]   = 1'b0;
              done_d[i]  = 1'b1;
            end else begin
              rem_d[i] = rem_q[i] - BURST_WIDTH'(1);
              led_d[i] = 1'b1;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase

      // A write overrides the running behaviour, including a burst that would
      // have completed on this same edge (no done pulse for an aborted burst).
      // Out-of-range channel indices match no channel and are dropped.
      if (accept && (cfg.cfg_ch == CH_W'(i))) begin
        h_d[i]    = cfg.cfg_half_period;
        cnt_d[i]  = '0;
        rem_d[i]  = '0;
        done_d[i] = 1'b0;
        case (cfg.cfg_mode)
          ST_OFF: begin
            state_d[i] = ST_OFF;
            led_d[i]   = 1'b0;
          end
          ST_ON: begin
            state_d[i] = ST_ON;
            led_d[i]   = 1'b1;
          end
          ST_BLINK: begin
            state_d[i] = ST_BLINK;
            led_d[i]   = 1'b1;
          end
          default: begin
            if (cfg.cfg_burst == '0) begin
              // Empty burst completes immediately.
              state_d[i] = ST_OFF;
              led_d[i]   = 1'b0;
              done_d[i]  = 1'b1;
            end else begin
              state_d[i] = ST_BURST;
              led_d[i]   = 1'b1;
              rem_d[i]   = cfg.cfg_burst;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_BLINK;
        cnt_q[i]   <= '0;
        h_q[i]     <= RST_H;
        rem_q[i]   <= '0;
      end
      led_q   <= '1;
      done_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        h_q[i]     <= h_d[i];
        rem_q[i]   <= rem_d[i];
      end
      led_q   <= led_d;
      done_q  <= done_d;
      ready_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_blink.sv
// -----------------------------------------------------------------------------
// tb_multi_blink
// Bench for multi_blink. A 4-channel instance carries the main scenarios; a
// 3-channel instance shares clock and reset and receives an out-of-range
// channel write. Expected outputs come from a closed-form description of each
// channel (mode, H, start edge, pulse count) and are queued per edge.
// -----------------------------------------------------------------------------
module tb_multi_blink;

  logic       clk;
  logic       reset;
  logic [3:0] led1, done1;
  logic [2:0] led2, done2;

  multi_blink_if #(.NUM_CH(4), .CNT_WIDTH(8), .BURST_WIDTH(8)) if1 ();
  multi_blink_if #(.NUM_CH(3), .CNT_WIDTH(8), .BURST_WIDTH(8)) if2 ();

  multi_blink #(
    .NUM_CH(4), .CNT_WIDTH(8), .BURST_WIDTH(8), .RESET_HALF_PERIOD(5)
  ) dut (
    .clk(clk), .reset(reset), .cfg(if1), .led(led1), .burst_done(done1)
  );

  multi_blink #(
    .NUM_CH(3), .CNT_WIDTH(8), .BURST_WIDTH(8), .RESET_HALF_PERIOD(5)
  ) dut3 (
    .clk(clk), .reset(reset), .cfg(if2), .led(led2), .burst_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel descriptors: [0..3] for the 4-channel DUT, [4..6] for the 3-channel DUT.
  logic [1:0] m_mode [7];
  int         m_h    [7];
  int         m_t0   [7];
  int         m_n    [7];
  logic       rdy_m;
  int         cyc;
  int         errors;
  int         checks;
  logic [15:0] sb_q [$];
  logic [15:0] exp_v, obs_v;

  function automatic logic exp_led(logic [1:0] m, int h, int t0, int n, int e);
    int k;
    k = e - t0;
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return ((k / h) % 2) == 0;
      default: return (k < 2 * n * h) ? (((k / h) % 2) == 0) : 1'b0;
    endcase
  endfunction

  function automatic logic exp_done(logic [1:0] m, int h, int t0, int n, int e);
    return (m == 2'b11) && ((e - t0) == 2 * n * h);
  endfunction

  function automatic logic [15:0] observed();
    return {led1, done1, if1.cfg_ready, led2, done2, if2.cfg_ready};
  endfunction

  task automatic load(int idx, logic [1:0] mode, int hp, int n, int nx);
    m_h[idx]  = (hp == 0) ? 1 : hp;
    m_t0[idx] = nx;
    m_n[idx]  = n;
    // An empty burst is described as a burst that ends on its own start edge.
    m_mode[idx] = mode;
  endtask

  // Apply the current inputs to the descriptors, queue what the next edge must
  // produce, then advance to just after that edge.
  task automatic advance();
    int nx;
    logic [3:0] l1, d1;
    logic [2:0] l2, d2;
    nx = cyc + 1;
    if (reset) begin
      for (int i = 0; i < 7; i++) load(i, 2'b10, 5, 0, nx);
    end else if (rdy_m) begin
      if (if1.cfg_valid && (int'(if1.cfg_ch) < 4))
        load(int'(if1.cfg_ch), if1.cfg_mode, int'(if1.cfg_half_period),
             int'(if1.cfg_burst), nx);
      if (if2.cfg_valid && (int'(if2.cfg_ch) < 3))
        load(4 + int'(if2.cfg_ch), if2.cfg_mode, int'(if2.cfg_half_period),
             int'(if2.cfg_burst), nx);
    end
    rdy_m = !reset;
    for (int i = 0; i < 4; i++) begin
      l1[i] = exp_led(m_mode[i], m_h[i], m_t0[i], m_n[i], nx);
      d1[i] = exp_done(m_mode[i], m_h[i], m_t0[i], m_n[i], nx);
    end
    for (int i = 0; i < 3; i++) begin
      l2[i] = exp_led(m_mode[4+i], m_h[4+i], m_t0[4+i], m_n[4+i], nx);
      d2[i] = exp_done(m_mode[4+i], m_h[4+i], m_t0[4+i], m_n[4+i], nx);
    end
    sb_q.push_back({l1, d1, rdy_m, l2, d2, rdy_m});
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic write1(logic v, logic [1:0] ch, logic [1:0] mode, int hp, int n);
    if1.cfg_valid       = v;
    if1.cfg_ch          = ch;
    if1.cfg_mode        = mode;
    if1.cfg_half_period = 8'(hp);
    if1.cfg_burst       = 8'(n);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 14; c++) begin
      reset = (c < 2);
      advance();
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_blink();
    for (int c = 0; c < 15; c++) begin
      if (c == 0) write1(1'b1, 2'd1, 2'b10, 3, 0);
      else        write1(1'b0, 2'd0, 2'b00, 0, 0);
      advance();
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL blink_h3 cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_burst();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 17; c++) begin
      if (c == 0) write1(1'b1, 2'd2, 2'b11, 2, 3);
      else        write1(1'b0, 2'd0, 2'b00, 0, 0);
      advance();
      if (done1[2]) pulses++;
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL burst_n3 cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL burst_done_count got=%0d want=1", pulses);
    end
  endtask

  task automatic test_zero_cases();
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      write1(1'b1, 2'd0, 2'b11, 4, 0);
      else if (c == 3) write1(1'b1, 2'd3, 2'b10, 0, 0);
      else             write1(1'b0, 2'd0, 2'b00, 0, 0);
      advance();
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL zero_burst_zero_h cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 13; c++) begin
      case (c)
        0:       write1(1'b1, 2'd0, 2'b10, 4, 0);
        1:       write1(1'b1, 2'd1, 2'b10, 2, 0);
        2:       write1(1'b1, 2'd3, 2'b01, 7, 0);
        default: write1(1'b0, 2'd0, 2'b00, 0, 0);
      endcase
      advance();
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 36; c++) begin
      reset = 1'b0;
      case (c)
        0:       write1(1'b1, 2'd2, 2'b11, 2, 3);
        5:       write1(1'b1, 2'd2, 2'b01, 2, 0);
        18:      write1(1'b1, 2'd1, 2'b11, 3, 2);
        22: begin
          write1(1'b1, 2'd1, 2'b01, 1, 0);
          reset = 1'b1;
        end
        default: write1(1'b0, 2'd0, 2'b00, 0, 0);
      endcase
      advance();
      if (done1[2] || done1[1]) pulses++;
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL abort cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
    end
    reset = 1'b0;
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d want=0", pulses);
    end
  endtask

  task automatic test_out_of_range();
    for (int c = 0; c < 12; c++) begin
      if2.cfg_valid       = (c == 1) || (c == 2);
      if2.cfg_ch          = 2'd3;
      if2.cfg_mode        = (c == 1) ? 2'b00 : 2'b11;
      if2.cfg_half_period = 8'd1;
      if2.cfg_burst       = 8'd0;
      advance();
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL ch_out_of_range cyc=%0d got=%b want=%b", cyc, obs_v, exp_v);
      end
    end
    if2.cfg_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rdy_m  = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 7; i++) load(i, 2'b10, 5, 0, 0);
    write1(1'b0, 2'd0, 2'b00, 0, 0);
    if2.cfg_valid       = 1'b0;
    if2.cfg_ch          = '0;
    if2.cfg_mode        = 2'b00;
    if2.cfg_half_period = '0;
    if2.cfg_burst       = '0;

    test_reset();
    test_blink();
    test_burst();
    test_zero_cases();
    test_back_to_back();
    test_abort();
    test_out_of_range();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
